// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the minutes:seconds BCD timer: FSM encoding,
// digit limits, packing positions and the load-legality helper.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int          DIGIT_W      = 4;
  localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
  localparam logic [3:0]  ONES_MAX     = 4'd9;

  // Nibble positions inside {min_tens, min_ones, sec_tens, sec_ones}.
  localparam int SEC_ONES_LSB = 0;
  localparam int SEC_TENS_LSB = 4;
  localparam int MIN_ONES_LSB = 8;
  localparam int MIN_TENS_LSB = 12;

  function automatic logic bcd_legal(input logic [15:0] v,
                                     input logic [3:0]  min_tens_max);
    return (v[SEC_ONES_LSB +: DIGIT_W] <= ONES_MAX)     &&
           (v[SEC_TENS_LSB +: DIGIT_W] <= SEC_TENS_MAX) &&
           (v[MIN_ONES_LSB +: DIGIT_W] <= ONES_MAX)     &&
           (v[MIN_TENS_LSB +: DIGIT_W] <= min_tens_max);
  endfunction

endpackage

// File: rtl/bcd_timer_if.sv
// Control and display signals between the timer and its environment;
// the master side drives control, the slave side is the timer itself.
interface bcd_timer_if;
  logic        tick;
  logic        mode;
  logic        start;
  logic        stop;
  logic        clear;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] digits;
  logic        running;
  logic        done;

  modport master (
    output tick, mode, start, stop, clear, load, load_value,
    input  digits, running, done
  );

  modport slave (
    input  tick, mode, start, stop, clear, load, load_value,
    output digits, running, done
  );
endinterface

// File: rtl/bcd_timer_digit.sv
// One mod-(MAX+1) BCD digit that counts up or down and reports its
// terminal count combinationally so digits can be chained.
module bcd_digit #(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,     // 0 = up, 1 = down
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       carry,
  output logic       borrow
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  logic [3:0] q_q, q_d;

  always_comb begin
    // NOTE: default assignment first so every path drives q_d; no latch.
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      if (dir) q_d = (q_q == 4'd0)  ? MAX_V : q_q - 4'd1;
      else     q_d = (q_q == MAX_V) ? 4'd0  : q_q + 4'd1;
    end
  end

  // NOTE: async active-low reset in the sensitivity list; state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 4'd0;
    else        q_q <= q_d;
  end

  assign q      = q_q;
  assign carry  = !dir && (q_q == MAX_V);
  assign borrow =  dir && (q_q == 4'd0);

endmodule

// File: rtl/bcd_timer.sv
// Minutes:seconds up/down timer advanced by one-cycle ticks, with
// start/stop/clear/validated-load control and a one-cycle done pulse.
module bcd_timer
  import timer_pkg::*;
#(
  parameter int MIN_TENS_MAX = 5
) (
  input  logic        clock,
  input  logic        reset,
  bcd_timer_if.slave  bus
);

  localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

  state_e      state_q, state_d;
  logic        running_q;
  logic        done_q;

  logic [15:0] digits;
  logic [3:0]  dig_en;
  logic [3:0]  carry, borrow;
  logic        dig_load;
  logic [15:0] dig_d;

  logic        load_ok;
  logic        tick_run;
  logic        up_wrap, down_zero, at_one;
  logic        step_en;
  logic        fire;

  assign load_ok   = bus.load && (state_q != ST_RUN) && bcd_legal(bus.load_value, MT_MAX);
  assign tick_run  = (state_q == ST_RUN) && bus.tick && !bus.clear;

  // All-carry means the value sits at the top of the range while counting up;
  // all-borrow means 00:00 while counting down.
  assign up_wrap   = &carry;
  assign down_zero = &borrow;
  assign at_one    = (digits == 16'h0001);

  assign step_en   = tick_run && !down_zero;
  assign fire      = tick_run && (bus.mode ? (down_zero || at_one) : up_wrap);

  assign dig_load  = bus.clear || load_ok;
  assign dig_d     = bus.clear ? 16'h0000 : bus.load_value;

  assign dig_en[0] = step_en;
  assign dig_en[1] = dig_en[0] && (carry[0] || borrow[0]);
  assign dig_en[2] = dig_en[1] && (carry[1] || borrow[1]);
  assign dig_en[3] = dig_en[2] && (carry[2] || borrow[2]);

  bcd_digit #(.MAX(9)) u_sec_ones (
    .clk(clock), .rst_n(reset), .en(dig_en[0]), .dir(bus.mode), .load(dig_load),
    .d(dig_d[SEC_ONES_LSB +: DIGIT_W]), .q(digits[SEC_ONES_LSB +: DIGIT_W]),
    .carry(carry[0]), .borrow(borrow[0])
  );

  bcd_digit #(.MAX(5)) u_sec_tens (
    .clk(clock), .rst_n(reset), .en(dig_en[1]), .dir(bus.mode), .load(dig_load),
    .d(dig_d[SEC_TENS_LSB +: DIGIT_W]), .q(digits[SEC_TENS_LSB +: DIGIT_W]),
    .carry(carry[1]), .borrow(borrow[1])
  );

  bcd_digit #(.MAX(9)) u_min_ones (
    .clk(clock), .rst_n(reset), .en(dig_en[2]), .dir(bus.mode), .load(dig_load),
    .d(dig_d[MIN_ONES_LSB +: DIGIT_W]), .q(digits[MIN_ONES_LSB +: DIGIT_W]),
    .carry(carry[2]), .borrow(borrow[2])
  );

  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clock), .rst_n(reset), .en(dig_en[3]), .dir(bus.mode), .load(dig_load),
    .d(dig_d[MIN_TENS_LSB +: DIGIT_W]), .q(digits[MIN_TENS_LSB +: DIGIT_W]),
    .carry(carry[3]), .borrow(borrow[3])
  );

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
    end else if (load_ok) begin
      if (state_q == ST_DONE) state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_PAUSE: if (bus.start && !bus.stop) state_d = ST_RUN;
        // A finishing countdown takes precedence over a simultaneous stop.
        ST_RUN: begin
          if (fire && bus.mode) state_d = ST_DONE;
          else if (bus.stop)    state_d = ST_PAUSE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= fire;
    end
  end

  assign bus.digits  = digits;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_timer.sv
// Directed stimulus with a scoreboard queue of expected outputs; a monitor
// compares every cycle while the queue holds entries.
module tb_bcd_timer;

  logic clock;
  logic reset;

  bcd_timer_if bus ();

  bcd_timer #(.MIN_TENS_MAX(5)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] dig;
    logic        run;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mon_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Drive one cycle of inputs; the expected post-edge outputs are queued.
  task automatic cyc(input logic t, input logic m, input logic sa, input logic so,
                     input logic cl, input logic ld, input logic [15:0] lv,
                     input logic [15:0] e_dig, input logic e_run, input logic e_done);
    exp_t e;
    @(negedge clock);
    bus.tick = t; bus.mode = m; bus.start = sa; bus.stop = so;
    bus.clear = cl; bus.load = ld; bus.load_value = lv;
    @(posedge clock);
    e.dig = e_dig; e.run = e_run; e.done = e_done;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_idx++;
        check($sformatf("digits[%0d]", mon_idx),  bus.digits,  e.dig);
        check($sformatf("running[%0d]", mon_idx), bus.running, e.run);
        check($sformatf("done[%0d]", mon_idx),    bus.done,    e.done);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b0;
    bus.tick = 0; bus.mode = 0; bus.start = 0; bus.stop = 0;
    bus.clear = 0; bus.load = 0; bus.load_value = 16'h0000;
    #12;
    check("reset_digits",  bus.digits,  16'h0000);
    check("reset_running", bus.running, 1'b0);
    check("reset_done",    bus.done,    1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Count up 61 ticks from 00:00 (back-to-back ticks), done never fires.
    cyc(0,0,1,0,0,0,16'h0, 16'h0000,1,0);
    for (int k = 1; k <= 61; k++) cyc(1,0,0,0,0,0,16'h0, to_bcd(k),1,0);

    // Wrap at 59:59; a tick on the start edge does not count.
    cyc(0,0,0,0,1,0,16'h0,    16'h0000,0,0);
    cyc(0,0,0,0,0,1,16'h5958, 16'h5958,0,0);
    cyc(1,0,1,0,0,0,16'h0,    16'h5958,1,0);
    cyc(1,0,0,0,0,0,16'h0,    16'h5959,1,0);
    cyc(1,0,0,0,0,0,16'h0,    16'h0000,1,1);
    cyc(0,0,0,0,0,0,16'h0,    16'h0000,1,0);

    // Countdown 00:02 to DONE, then DONE ignores tick/start/illegal load.
    cyc(0,0,0,0,1,0,16'h0,    16'h0000,0,0);
    cyc(0,1,0,0,0,1,16'h0002, 16'h0002,0,0);
    cyc(0,1,1,0,0,0,16'h0,    16'h0002,1,0);
    cyc(1,1,0,0,0,0,16'h0,    16'h0001,1,0);
    cyc(1,1,0,0,0,0,16'h0,    16'h0000,0,1);
    cyc(0,1,0,0,0,0,16'h0,    16'h0000,0,0);
    cyc(1,1,0,0,0,0,16'h0,    16'h0000,0,0);
    cyc(0,1,1,0,0,0,16'h0,    16'h0000,0,0);
    cyc(0,1,0,0,0,1,16'h6000, 16'h0000,0,0);
    // A legal load leaves DONE for IDLE, from where start works again.
    cyc(0,1,0,0,0,1,16'h0030, 16'h0030,0,0);
    cyc(0,1,1,0,0,0,16'h0,    16'h0030,1,0);

    // Start from 00:00 in down mode: next tick fires done without underflow.
    cyc(0,1,0,0,1,0,16'h0,    16'h0000,0,0);
    cyc(0,1,1,0,0,0,16'h0,    16'h0000,1,0);
    cyc(1,1,0,0,0,0,16'h0,    16'h0000,0,1);
    cyc(0,1,0,0,0,0,16'h0,    16'h0000,0,0);

    // Stop with a tick at 00:09: step applied, then PAUSE ignores ticks.
    cyc(0,0,0,0,1,0,16'h0,    16'h0000,0,0);
    cyc(0,0,0,0,0,1,16'h0009, 16'h0009,0,0);
    cyc(0,0,1,0,0,0,16'h0,    16'h0009,1,0);
    cyc(1,0,0,1,0,0,16'h0,    16'h0010,0,0);
    for (int k = 0; k < 5; k++) cyc(1,0,0,0,0,0,16'h0, 16'h0010,0,0);
    cyc(0,0,1,0,0,0,16'h0,    16'h0010,1,0);
    cyc(1,0,0,0,0,0,16'h0,    16'h0011,1,0);
    // start and stop together: stop wins in RUN and in PAUSE.
    cyc(0,0,1,1,0,0,16'h0,    16'h0011,0,0);
    cyc(0,0,1,1,0,0,16'h0,    16'h0011,0,0);
    cyc(0,0,1,0,0,0,16'h0,    16'h0011,1,0);

    // Load validation in IDLE, load ignored in RUN, clear beats load.
    cyc(0,0,0,0,1,0,16'h0,    16'h0000,0,0);
    cyc(0,0,0,0,0,1,16'h0A00, 16'h0000,0,0);
    cyc(0,0,0,0,0,1,16'h6000, 16'h0000,0,0);
    cyc(0,0,0,0,0,1,16'h0060, 16'h0000,0,0);
    cyc(0,0,0,0,0,1,16'h000A, 16'h0000,0,0);
    cyc(0,0,0,0,0,1,16'h5959, 16'h5959,0,0);
    cyc(0,0,1,0,0,0,16'h0,    16'h5959,1,0);
    cyc(0,0,0,0,0,1,16'h1234, 16'h5959,1,0);
    cyc(0,0,0,0,1,1,16'h1234, 16'h0000,0,0);
    cyc(0,0,1,0,0,0,16'h0,    16'h0000,1,0);

    // mode change mid-run affects the following tick only.
    cyc(1,0,0,0,0,0,16'h0,    16'h0001,1,0);
    cyc(1,1,0,0,0,0,16'h0,    16'h0000,0,1);

    // Asynchronous reset mid-countdown at 01:30.
    cyc(0,1,0,0,1,0,16'h0,    16'h0000,0,0);
    cyc(0,1,0,0,0,1,16'h0131, 16'h0131,0,0);
    cyc(0,1,1,0,0,0,16'h0,    16'h0131,1,0);
    cyc(1,1,0,0,0,0,16'h0,    16'h0130,1,0);
    @(negedge clock);
    #2;
    reset = 1'b0;
    bus.tick = 1'b1;
    #1;
    check("async_rst_digits",  bus.digits,  16'h0000);
    check("async_rst_running", bus.running, 1'b0);
    check("async_rst_done",    bus.done,    1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("held_rst_digits", bus.digits, 16'h0000);
    reset = 1'b1;
    bus.tick = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1,1,0,0,0,0,16'h0, 16'h0000,0,0);

    for (int k = 0; k < 10; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
    end
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_timer.md
# bcd_timer

Minutes:seconds up/down timer that consumes the one-cycle `tick` pulse produced by the team's `custom_clock` divider (PERIOD = 1 s) and advances a four-digit BCD value once per tick. It sits between the divider and the seven-segment display driver, and provides start/stop/clear/load control for stopwatch and countdown use.

## Interface

Parameters:
- `MIN_TENS_MAX`, 5: highest legal minutes-tens digit; the counting range is 00:00 to (`MIN_TENS_MAX`)9:59.

Ports:
- `clock`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `tick`  input  1  one-cycle enable pulse from `custom_clock`; one pulse equals one count step.
- `mode`  input  1  0 = count up, 1 = count down; sampled on every tick.
- `start`  input  1  level or pulse; begin or resume counting.
- `stop`  input  1  pause counting.
- `clear`  input  1  force 00:00 and IDLE.
- `load`  input  1  load `load_value` (validated).
- `load_value`  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}.
- `digits`  output  16  current BCD value, same packing as `load_value`.
- `running`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse on countdown reaching 00:00, or on count-up wrap.

## Operation

- The state machine has four states: IDLE, RUN, PAUSE and DONE. The reset state is IDLE.
- Control priority each cycle: `clear` > `load` > `stop` > `start` > `tick`.
- `clear`, from any state: `digits` ← 0000, state ← IDLE.
- `load`:
  - Accepted only in IDLE, PAUSE or DONE.
  - Accepted only if the value is legal: sec_ones ≤ 9, sec_tens ≤ 5, min_ones ≤ 9, min_tens ≤ `MIN_TENS_MAX`.
  - When accepted, `digits` ← `load_value`. DONE goes to IDLE; IDLE and PAUSE keep their state.
  - An illegal value, or `load` asserted in RUN, is ignored with no side effects.
- IDLE: `start` → RUN. This applies even when `mode`=1 and the value is 00:00; the next tick then fires `done` and the state goes to DONE without changing `digits`.
- RUN, on a tick:
  - `mode`=0: increment with BCD carries sec_ones→sec_tens→min_ones→min_tens.
  - At the maximum value (e.g. 59:59), the increment wraps to 00:00, pulses `done`, and the state stays RUN.
  - `mode`=1: decrement with borrows. The step that lands on 00:00 pulses `done` and moves the state to DONE.
  - At 00:00, a down tick does not underflow: `digits` are held, `done` pulses, and the state goes to DONE.
- RUN with `stop` asserted → PAUSE. If `tick` is high in the same cycle, the step is still applied before pausing.
- PAUSE: ticks are ignored; `start` → RUN.
- DONE: `digits` are held and `start` is ignored. Leave DONE only by `clear` or an accepted `load`.
- `start` and `stop` asserted together: `stop` wins.

## Timing

- All outputs are registered.
- Reset values: `digits`=0000, `running`=0, `done`=0, state IDLE. Reset is asynchronous and applies mid-count with no stale pulse.
- Count latency: a tick sampled at edge N makes `digits` and `done` valid after edge N.
  - `done` is high exactly one cycle, aligned with the `digits` update.
- Control latency: `start`/`stop`/`clear`/`load` take effect at the sampling edge.
  - `running` changes in the same cycle as the state.
- A tick coinciding with the `start` edge in IDLE or PAUSE does not count; counting begins with the next tick.
- `mode` may change at any time and affects only subsequent ticks.
- Back-to-back ticks on consecutive cycles must each count, to support fast-tick simulation.

## Structure

- Package `timer_pkg`:
  - state encoding (2-bit enum/localparams for IDLE, RUN, PAUSE, DONE);
  - digit limit constants (SEC_TENS_MAX=5, ONES_MAX=9);
  - the BCD packing index constants.
- Sub-module `bcd_digit`: mod-N up/down digit counter.
  - Parameter: `MAX`.
  - Inputs: `en`, `dir`, `load`, `d`.
  - Outputs: `q`, `carry`/`borrow` (combinational terminal-count).
  - Four instances are chained, with `MAX` = 9, 5, 9, `MIN_TENS_MAX`.
- Top level holds the FSM, load validation and the `done` register.

## Test plan

- Reset, then `start` with `mode`=0 and 61 ticks → `digits`=0101, `running`=1, `done` never high.
- `load` 5958 in IDLE, `start`, `mode`=0, 2 ticks → 5959 then 0000 with one `done` pulse; state remains RUN.
- `load` 0002, `mode`=1, `start`, 3 ticks → 0001, then 0000 with `done` (one cycle); state DONE; third tick, `start` and `load` 6000 are all ignored.
- In RUN at 0009, assert `stop` in the same cycle as a tick → `digits`=0010, state PAUSE; 5 further ticks leave 0010; `start` resumes.
- `load` 0A00 or 6000 (illegal) in IDLE → `digits` unchanged. `load` asserted in RUN → ignored. `clear` and `load` together → 0000, IDLE.
- Drop `reset` mid-countdown at 0130 → all outputs 0 immediately (asynchronous), no `done` pulse after release.
